eth_cmd_resp: RTL and testbench

Command-reply framer for the UDP control path. Queues (address, data) reply requests from the register/status logic and serializes each as a fixed 9-byte frame into the Ethernet transmit byte FIFO. After each frame it issues one packet-transmit request and waits for `tx_done` before starting the next frame. It is the transmit-side counterpart of the command parser that decodes frames from the receive FIFO, and runs in the 125 MHz Ethernet domain.

---
 rtl/eth_cmd_resp.sv | 167 ++++++++++++++++
 tb/tb_eth_cmd_resp.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_resp.sv
// eth_cmd_resp: reply framer for the UDP control path (125 MHz Ethernet domain).
// Queues (addr, data) replies and serializes each one as a 9-byte frame:
//   HDR0 HDR1 addr d[31:24] d[23:16] d[15:8] d[7:0] CS TAIL
// CS is the 8-bit sum of addr and the four data bytes.
// After each frame it raises pkt_tx_en for one cycle, then waits for tx_done
// (bounded by TIMEOUT) before starting the next frame.
//
// state      | meaning
// S_IDLE     | waiting for a non-empty reply queue
// S_LOAD     | pop head entry into shadow, compute checksum, clear byte index
// S_WRITE    | push frame bytes into the TX byte FIFO, stalling on fifo_full
// S_KICK     | one-cycle packet transmit request, clear wait counter
// S_WAIT     | wait for tx_done or timeout

module eth_cmd_resp #(
    parameter int unsigned DEPTH   = 4,
    parameter logic [7:0]  HDR0    = 8'h55,
    parameter logic [7:0]  HDR1    = 8'hA5,
    parameter logic [7:0]  TAIL    = 8'hF0,
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_addr,
    input  logic [31:0] rsp_data,
    output logic        rsp_ready,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_wrdata,
    output logic        pkt_tx_en,
    output logic [15:0] pkt_length,
    input  logic        tx_done,
    output logic        busy,
    output logic [7:0]  drop_cnt,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_KICK, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [39:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic        q_full, q_empty, full_nxt;
    logic        push, pop, drop;
    logic [39:0] head, shadow;
    logic [7:0]  cs;
    logic [3:0]  idx;
    logic [15:0] wait_cnt;
    logic        wait_to;
    logic [7:0]  frame_byte;

    assign pkt_length = 16'd9;

    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push while full is dropped even when a pop happens in the same cycle.
    assign push = rsp_valid && !q_full;
    assign drop = rsp_valid && q_full;
    assign pop  = (state == S_LOAD);

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    assign head = mem[rd_ptr[AW-1:0]];

    // Timeout fires on the TIMEOUT-th WAIT cycle without tx_done.
    assign wait_to = (state == S_WAIT) && !tx_done &&
                     (({1'b0, wait_cnt} + 17'd1) == {1'b0, TIMEOUT});

    // Queue pointers, registered ready flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_ready <= 1'b1;
            drop_cnt  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            rsp_ready <= !full_nxt;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Queue storage; entries are captured at push time.
    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr[AW-1:0]] <= {rsp_addr, rsp_data};
    end

    // State register, frame shadow, byte index, wait counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            shadow      <= '0;
            cs          <= '0;
            idx         <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            if (state == S_LOAD) begin
                shadow <= head;
                cs     <= head[39:32] + head[31:24] + head[23:16] + head[15:8] + head[7:0];
                idx    <= '0;
            end
            if (state == S_WRITE && fifo_wrreq && idx != 4'd8)
                idx <= idx + 4'd1;
            if (state == S_KICK)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 16'd1;
            if (wait_to)
                timeout_err <= 1'b1;
        end
    end

    // Byte selection for the current frame index.
    always_comb begin
        frame_byte = TAIL;
        case (idx)
            4'd0:    frame_byte = HDR0;
            4'd1:    frame_byte = HDR1;
            4'd2:    frame_byte = shadow[39:32];
            4'd3:    frame_byte = shadow[31:24];
            4'd4:    frame_byte = shadow[23:16];
            4'd5:    frame_byte = shadow[15:8];
            4'd6:    frame_byte = shadow[7:0];
            4'd7:    frame_byte = cs;
            default: frame_byte = TAIL;
        endcase
    end

    // Next-state and strobe outputs.
    always_comb begin
        state_nxt   = state;
        fifo_wrreq  = 1'b0;
        fifo_wrdata = 8'h00;
        pkt_tx_en   = 1'b0;
        case (state)
            S_IDLE:  if (!q_empty) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_WRITE;
            S_WRITE: begin
                fifo_wrreq  = !fifo_full;
                fifo_wrdata = frame_byte;
                if (!fifo_full && idx == 4'd8)
                    state_nxt = S_KICK;
            end
            S_KICK: begin
                pkt_tx_en = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:  if (tx_done || wait_to) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_cmd_resp.sv
// Bench for eth_cmd_resp: queue/frame reference model plus directed and random stimulus.
module tb_eth_cmd_resp;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;
    localparam int P_IDLE = 0, P_POP = 1, P_SEND = 2, P_KICK = 3, P_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1, rsp_valid = 1'b0, fifo_full = 1'b0, tx_done = 1'b0;
    logic [7:0]  rsp_addr = 8'h00;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_ready, fifo_wrreq, pkt_tx_en, busy, timeout_err;
    logic [7:0]  fifo_wrdata, drop_cnt;
    logic [15:0] pkt_length;

    int checks = 0, errors = 0, cyc = 0;

    // reference model state
    logic [39:0] mq[$];
    int          m_ph = P_IDLE, m_pos = 0, m_waited = 0, m_drop = 0;
    logic        m_terr = 1'b0;
    logic [7:0]  m_frame [9];

    // observation log
    logic [7:0] wl_b[$];
    int         wl_c[$];
    int         kick_n = 0, kick_cyc = 0, terr_cyc = 0;
    bit         terr_seen = 0;

    logic [7:0] exp_basic [9] = '{8'h55, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15, 8'hF0};

    always #4 clk = ~clk;

    eth_cmd_resp #(.DEPTH(DEPTH), .TIMEOUT(16'(TMO))) dut (
        .clk(clk), .reset(reset), .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .fifo_full(fifo_full),
        .fifo_wrreq(fifo_wrreq), .fifo_wrdata(fifo_wrdata), .pkt_tx_en(pkt_tx_en),
        .pkt_length(pkt_length), .tx_done(tx_done), .busy(busy),
        .drop_cnt(drop_cnt), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [39:0] e, input int i);
        int s;
        s = (int'(e[39:32]) + int'(e[31:24]) + int'(e[23:16]) + int'(e[15:8]) + int'(e[7:0])) % 256;
        case (i)
            0: return 8'h55;
            1: return 8'hA5;
            2: return e[39:32];
            3: return e[31:24];
            4: return e[23:16];
            5: return e[15:8];
            6: return e[7:0];
            7: return 8'(s);
            default: return 8'hF0;
        endcase
    endfunction

    // model: advances once per rising edge from the inputs seen at that edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (reset) begin
            mq.delete();
            m_ph = P_IDLE; m_pos = 0; m_waited = 0; m_drop = 0; m_terr = 1'b0;
        end else begin
            bit was_full;
            logic [39:0] e;
            was_full = (mq.size() == DEPTH);
            case (m_ph)
                P_IDLE: if (mq.size() > 0) m_ph = P_POP;
                P_POP: begin
                    e = mq.pop_front();
                    for (int i = 0; i < 9; i++) m_frame[i] = fbyte(e, i);
                    m_pos = 0;
                    m_ph = P_SEND;
                end
                P_SEND: if (!fifo_full) begin
                    if (m_pos == 8) m_ph = P_KICK;
                    else m_pos = m_pos + 1;
                end
                P_KICK: begin m_waited = 0; m_ph = P_WAIT; end
                default: begin
                    if (tx_done) m_ph = P_IDLE;
                    else begin
                        m_waited = m_waited + 1;
                        if (m_waited == TMO) begin m_terr = 1'b1; m_ph = P_IDLE; end
                    end
                end
            endcase
            if (rsp_valid) begin
                if (was_full) begin
                    if (m_drop < 255) m_drop = m_drop + 1;
                end else mq.push_back({rsp_addr, rsp_data});
            end
        end
    end

    // compare process: every cycle, on the falling edge
    initial forever begin
        @(negedge clk);
        chk("cyc_rsp_ready", 32'(rsp_ready), 32'(mq.size() < DEPTH));
        chk("cyc_fifo_wrreq", 32'(fifo_wrreq), 32'(m_ph == P_SEND && !fifo_full));
        chk("cyc_fifo_wrdata", 32'(fifo_wrdata), 32'((m_ph == P_SEND) ? m_frame[m_pos] : 8'h00));
        chk("cyc_pkt_tx_en", 32'(pkt_tx_en), 32'(m_ph == P_KICK));
        chk("cyc_busy", 32'(busy), 32'(m_ph != P_IDLE));
        chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("cyc_timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("cyc_pkt_length", 32'(pkt_length), 32'd9);
        if (fifo_wrreq === 1'b1) begin wl_b.push_back(fifo_wrdata); wl_c.push_back(cyc); end
        if (pkt_tx_en === 1'b1) begin kick_n++; kick_cyc = cyc; end
        if (timeout_err === 1'b1 && !terr_seen) begin terr_seen = 1; terr_cyc = cyc; end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push1(input logic [7:0] a, input logic [31:0] d);
        rsp_valid = 1'b1; rsp_addr = a; rsp_data = d;
        step();
        rsp_valid = 1'b0; rsp_addr = 8'($urandom); rsp_data = $urandom;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1; step(); tx_done = 1'b0;
    endtask

    task automatic wait_kick(input string name, input int budget);
        int k0, n;
        k0 = kick_n; n = 0;
        while (kick_n == k0 && n < budget) begin step(); n++; end
        chk(name, 32'(kick_n != k0), 32'd1);
    endtask

    task automatic chk_frame(input string name, input int n0, input logic [39:0] e);
        chk({name, "_count"}, 32'(wl_b.size() - n0), 32'd9);
        if (wl_b.size() >= n0 + 9)
            for (int i = 0; i < 9; i++)
                chk($sformatf("%s_b%0d", name, i), 32'(wl_b[n0 + i]), 32'(fbyte(e, i)));
    endtask

    initial begin
        int n0, c0, k_a, n, hits, cnt34;

        repeat (3) step();
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_fifo_wrreq", 32'(fifo_wrreq), 32'd0);
        reset = 1'b0;
        step();

        chk("model_cs_basic", 32'(fbyte({8'h01, 32'h12345678}, 7)), 32'h15);
        chk("model_cs_wrap", 32'(fbyte({8'hFF, 32'hFFFFFFFF}, 7)), 32'hFB);

        // basic frame
        n0 = wl_b.size(); c0 = cyc;
        push1(8'h01, 32'h12345678);
        wait_kick("basic_kick", 60);
        chk("basic_count", 32'(wl_b.size() - n0), 32'd9);
        if (wl_b.size() >= n0 + 9) begin
            for (int i = 0; i < 9; i++)
                chk($sformatf("basic_b%0d", i), 32'(wl_b[n0 + i]), 32'(exp_basic[i]));
            chk("basic_first_write_cycle", 32'(wl_c[n0]), 32'(c0 + 3));
            chk("basic_last_write_cycle", 32'(wl_c[n0 + 8]), 32'(c0 + 11));
        end
        chk("basic_kick_cycle", 32'(kick_cyc), 32'(c0 + 12));
        repeat (19) step();
        chk("basic_busy_waiting", 32'(busy), 32'd1);
        pulse_done();
        step();
        chk("basic_busy_after_done", 32'(busy), 32'd0);

        // checksum wrap
        n0 = wl_b.size();
        push1(8'hFF, 32'hFFFFFFFF);
        wait_kick("wrap_kick", 60);
        if (wl_b.size() >= n0 + 9) chk("wrap_cs", 32'(wl_b[n0 + 7]), 32'hFB);
        else chk("wrap_count", 32'(wl_b.size() - n0), 32'd9);
        repeat ($urandom_range(1, 10)) step();
        pulse_done();
        repeat (2) step();

        // backpressure while byte index 4 is pending
        n0 = wl_b.size(); c0 = cyc;
        push1(8'h01, 32'h12345678);
        repeat (6) step();
        fifo_full = 1'b1;
        repeat (5) step();
        fifo_full = 1'b0;
        wait_kick("bp_kick", 60);
        chk("bp_total_writes", 32'(wl_b.size() - n0), 32'd9);
        hits = 0; cnt34 = 0;
        for (int i = n0; i < wl_b.size(); i++) begin
            if (wl_c[i] >= c0 + 7 && wl_c[i] <= c0 + 11) hits++;
            if (wl_b[i] == 8'h34) cnt34++;
        end
        chk("bp_writes_while_full", 32'(hits), 32'd0);
        chk("bp_byte34_once", 32'(cnt34), 32'd1);
        if (wl_b.size() >= n0 + 9) chk("bp_byte4_cycle", 32'(wl_c[n0 + 4]), 32'(c0 + 12));
        repeat (3) step();
        pulse_done();
        repeat (2) step();

        // queue overflow
        for (int i = 0; i < 6; i++) begin
            rsp_valid = 1'b1; rsp_addr = 8'($urandom); rsp_data = $urandom;
            step();
        end
        rsp_valid = 1'b0;
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("ovf_rsp_ready", 32'(rsp_ready), 32'd0);
        for (int f = 0; f < 5; f++) begin
            wait_kick($sformatf("ovf_kick%0d", f), 200);
            repeat ($urandom_range(1, 20)) step();
            pulse_done();
        end
        repeat (2) step();
        chk("ovf_drained_ready", 32'(rsp_ready), 32'd1);
        chk("ovf_drained_busy", 32'(busy), 32'd0);

        // timeout, with a stray tx_done during WRITE
        push1(8'hA0, 32'hCAFEF00D);
        push1(8'hA1, 32'h01020304);
        repeat (3) step();
        pulse_done();
        wait_kick("tmo_kick_a", 60);
        k_a = kick_cyc;
        n = 0;
        while (!terr_seen && n < 300) begin step(); n++; end
        chk("tmo_flag_set", 32'(terr_seen), 32'd1);
        chk("tmo_flag_cycle", 32'(terr_cyc), 32'(k_a + TMO + 1));
        n0 = wl_b.size();
        wait_kick("tmo_kick_b", 60);
        chk_frame("tmo_next", n0, {8'hA1, 32'h01020304});
        repeat (4) step();
        pulse_done();
        repeat (2) step();

        // reset mid-WRITE at byte 5
        push1(8'h3C, 32'h89ABCDEF);
        push1(8'h3D, 32'h11223344);
        repeat (6) step();
        reset = 1'b1;
        step();
        chk("rstmid_rsp_ready", 32'(rsp_ready), 32'd1);
        chk("rstmid_fifo_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("rstmid_fifo_wrdata", 32'(fifo_wrdata), 32'd0);
        chk("rstmid_pkt_tx_en", 32'(pkt_tx_en), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rstmid_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        repeat (5) step();
        chk("rstmid_queue_empty", 32'(busy), 32'd0);
        n0 = wl_b.size();
        push1(8'h77, 32'hDEADBEEF);
        wait_kick("rstmid_kick", 60);
        chk_frame("rstmid_new", n0, {8'h77, 32'hDEADBEEF});
        repeat (2) step();
        pulse_done();

        // randomized traffic
        for (int t = 0; t < 800; t++) begin
            rsp_valid = ($urandom_range(0, 3) == 0);
            rsp_addr  = 8'($urandom);
            rsp_data  = $urandom;
            fifo_full = ($urandom_range(0, 4) == 0);
            tx_done   = ($urandom_range(0, 15) == 0);
            step();
        end
        rsp_valid = 1'b0;
        n = 0;
        while ((busy || mq.size() > 0) && n < 4000) begin
            fifo_full = ($urandom_range(0, 4) == 0);
            tx_done   = ($urandom_range(0, 7) == 0);
            step();
            n++;
        end
        fifo_full = 1'b0; tx_done = 1'b0;
        repeat (2) step();
        chk("rand_drained_busy", 32'(busy), 32'd0);
        chk("rand_drained_ready", 32'(rsp_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
